// File: rtl/usb_serial_bulk_ep_if.sv
// Endpoint-side bundle for the USB-serial bulk endpoint pair: the USB core's OUT/IN
// endpoint ports plus the byte-stream ports in the clk domain.
interface usb_serial_bulk_ep_if;
   logic       out_ep_req;
   logic       out_ep_grant;
   logic       out_ep_data_avail;
   logic       out_ep_setup;
   logic       out_ep_data_get;
   logic [7:0] out_ep_data;
   logic       out_ep_stall;
   logic       out_ep_acked;
   logic       in_ep_req;
   logic       in_ep_grant;
   logic       in_ep_data_free;
   logic       in_ep_data_put;
   logic [7:0] in_ep_data;
   logic       in_ep_data_done;
   logic       in_ep_stall;
   logic       in_ep_acked;
   logic [7:0] uart_tx_data;
   logic       uart_tx_strobe;
   logic       uart_tx_ready;
   logic [7:0] uart_rx_data;
   logic       uart_rx_valid;
   logic       uart_rx_ready;
   logic       tx_overflow;

   // The endpoint block itself.
   modport slave (
      input  out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_data, out_ep_acked,
      input  in_ep_grant, in_ep_data_free, in_ep_acked,
      input  uart_tx_data, uart_tx_strobe, uart_rx_ready,
      output out_ep_req, out_ep_data_get, out_ep_stall,
      output in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
      output uart_tx_ready, uart_rx_data, uart_rx_valid, tx_overflow
   );

   // The USB device core together with the byte-stream producer/consumer.
   modport master (
      output out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_data, out_ep_acked,
      output in_ep_grant, in_ep_data_free, in_ep_acked,
      output uart_tx_data, uart_tx_strobe, uart_rx_ready,
      input  out_ep_req, out_ep_data_get, out_ep_stall,
      input  in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
      input  uart_tx_ready, uart_rx_data, uart_rx_valid, tx_overflow
   );
endinterface

// File: rtl/usb_serial_bulk_ep.sv
// USB-serial bulk endpoint pair: RX FIFO fed from the OUT endpoint, TX FIFO drained into
// IN packets of up to MAX_PACKET bytes with idle-timeout flush and optional ZLP.
module usb_serial_bulk_ep #(
   parameter int TX_DEPTH     = 512,
   parameter int RX_DEPTH     = 64,
   parameter int MAX_PACKET   = 32,
   parameter int FLUSH_CYCLES = 48000,
   parameter bit ZLP_ENABLE   = 1'b1
) (
   input logic                 clk,
   input logic                 reset_n,
   usb_serial_bulk_ep_if.slave bus
);
   localparam int TXAW = $clog2(TX_DEPTH);
   localparam int RXAW = $clog2(RX_DEPTH);
   localparam int CNTW = $clog2(MAX_PACKET) + 1;
   localparam int TMRW = $clog2(FLUSH_CYCLES + 1);

   typedef logic [TXAW:0]   tx_lvl_t;
   typedef logic [RXAW:0]   rx_lvl_t;
   typedef logic [CNTW-1:0] cnt_t;
   typedef logic [TMRW-1:0] tmr_t;

   localparam tx_lvl_t TX_FULL  = tx_lvl_t'(TX_DEPTH);
   localparam tx_lvl_t TX_PKT   = tx_lvl_t'(MAX_PACKET);
   localparam tx_lvl_t TX_ONE   = tx_lvl_t'(1);
   localparam rx_lvl_t RX_FULL  = rx_lvl_t'(RX_DEPTH);
   localparam rx_lvl_t RX_PKT   = rx_lvl_t'(MAX_PACKET);
   localparam cnt_t    CNT_LAST = cnt_t'(MAX_PACKET - 1);
   localparam tmr_t    TMR_MAX  = tmr_t'(FLUSH_CYCLES);

   typedef enum logic [1:0] {IDLE, REQ, SEND, ZREQ} state_t;

   // ---------------- OUT endpoint -> RX FIFO ----------------
   logic [7:0]      rx_mem [RX_DEPTH];
   logic [RXAW-1:0] rx_wp, rx_rp;
   rx_lvl_t         rx_level, rx_free;
   logic            get, get_p1, rx_valid, rx_rd;

   assign rx_free  = RX_FULL - rx_level;
   // get_p1 is the single byte in flight between a get and its capture
   assign get      = reset_n & bus.out_ep_grant & bus.out_ep_data_avail &
                     (rx_free > rx_lvl_t'(get_p1));
   assign rx_valid = (rx_level != '0);
   assign rx_rd    = rx_valid & bus.uart_rx_ready;

   assign bus.out_ep_req      = reset_n & bus.out_ep_data_avail & (rx_free >= RX_PKT);
   assign bus.out_ep_data_get = get;
   assign bus.out_ep_stall    = 1'b0;
   assign bus.uart_rx_valid   = rx_valid;
   assign bus.uart_rx_data    = rx_valid ? rx_mem[rx_rp] : 8'h00;

   always_ff @(posedge clk) begin
      if (get_p1) rx_mem[rx_wp] <= bus.out_ep_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         get_p1   <= 1'b0;
         rx_wp    <= '0;
         rx_rp    <= '0;
         rx_level <= '0;
      end else begin
         get_p1   <= get;
         if (get_p1) rx_wp <= rx_wp + RXAW'(1);
         if (rx_rd)  rx_rp <= rx_rp + RXAW'(1);
         rx_level <= rx_level + rx_lvl_t'(get_p1) - rx_lvl_t'(rx_rd);
      end
   end

   // ---------------- TX FIFO write side ----------------
   logic [7:0]      tx_mem [TX_DEPTH];
   logic [TXAW-1:0] tx_wp, tx_rp;
   tx_lvl_t         tx_level;
   logic            tx_ready, tx_wr, tx_rd, tx_ovf;

   assign tx_ready = (tx_level != TX_FULL);
   assign tx_wr    = bus.uart_tx_strobe & tx_ready;

   assign bus.uart_tx_ready = tx_ready;
   assign bus.tx_overflow   = tx_ovf;

   always_ff @(posedge clk) begin
      if (tx_wr) tx_mem[tx_wp] <= bus.uart_tx_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_wp    <= '0;
         tx_rp    <= '0;
         tx_level <= '0;
         tx_ovf   <= 1'b0;
      end else begin
         if (tx_wr) tx_wp <= tx_wp + TXAW'(1);
         if (tx_rd) tx_rp <= tx_rp + TXAW'(1);
         tx_level <= tx_level + tx_lvl_t'(tx_wr) - tx_lvl_t'(tx_rd);
         if (bus.uart_tx_strobe & !tx_ready) tx_ovf <= 1'b1;
      end
   end

   // ---------------- IN packet FSM ----------------
   state_t state, state_nxt;
   cnt_t   cnt;
   tmr_t   tmr;
   logic   expired, zlp_pend, in_req, data_end, zlp_sent, pkt_end, last_full;
   logic   put_p1, done_p1;
   logic [7:0] data_p1;

   assign expired   = (tmr == TMR_MAX);
   assign pkt_end   = data_end | zlp_sent;
   assign last_full = (cnt == CNT_LAST) & (tx_level == TX_ONE) & !tx_wr;

   always_comb begin
      state_nxt = state;
      in_req    = 1'b0;
      tx_rd     = 1'b0;
      data_end  = 1'b0;
      zlp_sent  = 1'b0;
      case (state)
         IDLE: begin
            if (tx_level >= TX_PKT || (tx_level != '0 && expired))
               state_nxt = REQ;
            else if (ZLP_ENABLE && zlp_pend && expired)
               state_nxt = ZREQ;
         end
         REQ: begin
            in_req = 1'b1;
            if (bus.in_ep_grant) state_nxt = SEND;
         end
         SEND: begin
            in_req = !bus.in_ep_grant;
            if (bus.in_ep_grant && bus.in_ep_data_free && tx_level != '0) begin
               tx_rd = 1'b1;
               // full packet, or the FIFO runs dry on a flushed partial packet
               if (cnt == CNT_LAST || (tx_level == TX_ONE && !tx_wr)) begin
                  data_end  = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         ZREQ: begin
            in_req = 1'b1;
            if (bus.in_ep_grant) begin
               zlp_sent  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         tmr      <= '0;
         zlp_pend <= 1'b0;
         put_p1   <= 1'b0;
         done_p1  <= 1'b0;
         data_p1  <= 8'h00;
      end else begin
         state <= state_nxt;
         if (data_end)   cnt <= '0;
         else if (tx_rd) cnt <= cnt + cnt_t'(1);
         if (tx_wr || pkt_end)
            tmr <= '0;
         else if ((tx_level != '0 || zlp_pend) && !expired)
            tmr <= tmr + tmr_t'(1);
         if (data_end)                zlp_pend <= last_full;
         else if (tx_wr || zlp_sent)  zlp_pend <= 1'b0;
         put_p1  <= tx_rd;
         done_p1 <= pkt_end;
         if (tx_rd) data_p1 <= tx_mem[tx_rp];
      end
   end

   assign bus.in_ep_req       = in_req;
   assign bus.in_ep_data_put  = put_p1;
   assign bus.in_ep_data      = data_p1;
   assign bus.in_ep_data_done = done_p1;
   assign bus.in_ep_stall     = 1'b0;

   logic unused_inputs;
   assign unused_inputs = ^{bus.out_ep_setup, bus.out_ep_acked, bus.in_ep_acked};
endmodule

// File: tb/tb_usb_serial_bulk_ep.sv
// Directed bench for usb_serial_bulk_ep: IN packetising, flush/ZLP timing, OUT backpressure,
// TX overflow and mid-packet reset, with a short flush timeout.
module tb_usb_serial_bulk_ep;
  localparam int F = 64;

  logic clk;
  logic reset_n;
  usb_serial_bulk_ep_if bus ();

  usb_serial_bulk_ep #(
    .TX_DEPTH(512), .RX_DEPTH(64), .MAX_PACKET(32), .FLUSH_CYCLES(F), .ZLP_ENABLE(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IN-side observer: collects put bytes, data-packet lengths and ZLPs.
  logic [7:0] put_q[$];
  int         len_q[$];
  int         zlp_n = 0;
  int         cur = 0;
  always @(negedge clk) begin
    if (!reset_n) cur = 0;
    else begin
      if (bus.in_ep_data_put) begin
        put_q.push_back(bus.in_ep_data);
        cur = cur + 1;
      end
      if (bus.in_ep_data_done) begin
        if (bus.in_ep_data_put) len_q.push_back(cur);
        else zlp_n = zlp_n + 1;
        cur = 0;
      end
    end
  end

  int n_assert = 0;
  int n_fail = 0;
  int base_p, base_l, base_z, errs, issued, start_prev, stored;
  logic early, seen, exp_req, dropped;
  logic [7:0] pend;
  logic pend_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_bytes(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      bus.uart_tx_data   = first + 8'(i);
      bus.uart_tx_strobe = 1'b1;
      step();
    end
    bus.uart_tx_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_out_req"},   {31'd0, bus.out_ep_req}, 0);
    check({p, "_out_get"},   {31'd0, bus.out_ep_data_get}, 0);
    check({p, "_out_stall"}, {31'd0, bus.out_ep_stall}, 0);
    check({p, "_in_req"},    {31'd0, bus.in_ep_req}, 0);
    check({p, "_in_put"},    {31'd0, bus.in_ep_data_put}, 0);
    check({p, "_in_data"},   {24'd0, bus.in_ep_data}, 0);
    check({p, "_in_done"},   {31'd0, bus.in_ep_data_done}, 0);
    check({p, "_in_stall"},  {31'd0, bus.in_ep_stall}, 0);
    check({p, "_rx_valid"},  {31'd0, bus.uart_rx_valid}, 0);
    check({p, "_rx_data"},   {24'd0, bus.uart_rx_data}, 0);
    check({p, "_tx_ready"},  {31'd0, bus.uart_tx_ready}, 1);
    check({p, "_tx_ovf"},    {31'd0, bus.tx_overflow}, 0);
  endtask

  task automatic snap();
    base_p = put_q.size();
    base_l = len_q.size();
    base_z = zlp_n;
  endtask

  task automatic wait_pkts(input int n, input int budget);
    for (int c = 0; c < budget && len_q.size() < base_l + n; c++) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.out_ep_grant = 0; bus.out_ep_data_avail = 0; bus.out_ep_setup = 0;
    bus.out_ep_data = 8'h00; bus.out_ep_acked = 0;
    bus.in_ep_grant = 0; bus.in_ep_data_free = 0; bus.in_ep_acked = 0;
    bus.uart_tx_data = 8'h00; bus.uart_tx_strobe = 0; bus.uart_rx_ready = 0;
    #1;
    check_reset_outputs("rst");
    step();
    reset_n = 1'b1;
    step();
    bus.in_ep_grant = 1'b1;
    bus.in_ep_data_free = 1'b1;

    // 1: one full packet 0x00..0x1F, then a single ZLP after the flush timeout
    snap();
    wr_bytes(32, 8'h00);
    wait_pkts(1, 100);
    check("t1_pkts", len_q.size() - base_l, 1);
    if (len_q.size() > base_l) check("t1_len", len_q[base_l], 32);
    check("t1_puts", put_q.size() - base_p, 32);
    for (int i = 0; i < 32; i++)
      if (put_q.size() > base_p + i) check($sformatf("t1_byte%0d", i), {24'd0, put_q[base_p + i]}, i);
    repeat (F - 4) @(negedge clk);
    check("t1_no_early_zlp", zlp_n - base_z, 0);
    for (int c = 0; c < 30 && zlp_n == base_z; c++) @(negedge clk);
    check("t1_zlp", zlp_n - base_z, 1);
    repeat (2 * F) @(negedge clk);
    check("t1_single_zlp", zlp_n - base_z, 1);
    check("t1_no_extra_pkt", len_q.size() - base_l, 1);

    // 2: 5 bytes flushed as one short packet, no ZLP
    do_reset();
    snap();
    wr_bytes(5, 8'hA0);
    early = 1'b0;
    repeat (F) begin
      @(negedge clk);
      if (bus.in_ep_req) early = 1'b1;
    end
    check("t2_no_early_req", {31'd0, early}, 0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.in_ep_req) seen = 1'b1;
    end
    check("t2_req_after_flush", {31'd0, seen}, 1);
    wait_pkts(1, 20);
    check("t2_pkts", len_q.size() - base_l, 1);
    if (len_q.size() > base_l) check("t2_len", len_q[base_l], 5);
    for (int i = 0; i < 5; i++)
      if (put_q.size() > base_p + i) check($sformatf("t2_byte%0d", i), {24'd0, put_q[base_p + i]}, 32'hA0 + i);
    repeat (2 * F + 10) @(negedge clk);
    check("t2_no_zlp", zlp_n - base_z, 0);
    check("t2_no_extra_pkt", len_q.size() - base_l, 1);

    // 3: 40 bytes -> immediate 32-byte packet, flushed 8-byte packet, no ZLP
    do_reset();
    snap();
    wr_bytes(40, 8'h40);
    wait_pkts(1, 40);
    check("t3_first_pkt", len_q.size() - base_l, 1);
    if (len_q.size() > base_l) check("t3_len0", len_q[base_l], 32);
    repeat (F - 4) @(negedge clk);
    check("t3_no_early_second", len_q.size() - base_l, 1);
    wait_pkts(2, 40);
    check("t3_second_pkt", len_q.size() - base_l, 2);
    if (len_q.size() > base_l + 1) check("t3_len1", len_q[base_l + 1], 8);
    errs = 0;
    for (int i = 0; i < 40; i++)
      if (put_q.size() <= base_p + i || put_q[base_p + i] !== 8'h40 + 8'(i)) errs++;
    check("t3_byte_errors", errs, 0);
    repeat (2 * F + 10) @(negedge clk);
    check("t3_no_zlp", zlp_n - base_z, 0);

    // 4: host sends 64 bytes into a stalled RX consumer, then drain in order
    do_reset();
    bus.uart_rx_ready = 1'b0;
    bus.out_ep_grant = 1'b1;
    issued = 0; start_prev = 0; pend = 8'h00; pend_v = 1'b0; dropped = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk);
      #1;
      if (pend_v) bus.out_ep_data = pend;
      stored = start_prev;
      start_prev = issued;
      bus.out_ep_data_avail = (issued < 64);
      @(negedge clk);
      exp_req = bus.out_ep_data_avail && ((64 - stored) >= 32);
      check($sformatf("t4_req_c%0d", c), {31'd0, bus.out_ep_req}, {31'd0, exp_req});
      if (bus.out_ep_data_avail && !bus.out_ep_req) dropped = 1'b1;
      if (bus.out_ep_data_get) begin
        pend = 8'(issued);
        pend_v = 1'b1;
        issued++;
      end else pend_v = 1'b0;
    end
    bus.out_ep_data_avail = 1'b0;
    check("t4_issued", issued, 64);
    check("t4_req_dropped", {31'd0, dropped}, 1);
    repeat (5) @(negedge clk);
    check("t4_hold_valid", {31'd0, bus.uart_rx_valid}, 1);
    check("t4_hold_data", {24'd0, bus.uart_rx_data}, 0);
    step();
    bus.uart_rx_ready = 1'b1;
    errs = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.uart_rx_valid !== 1'b1 || bus.uart_rx_data !== 8'(i)) errs++;
    end
    check("t4_drain_errors", errs, 0);
    @(negedge clk);
    check("t4_empty_after", {31'd0, bus.uart_rx_valid}, 0);
    bus.uart_rx_ready = 1'b0;
    bus.out_ep_grant = 1'b0;

    // 5: fill TX completely, one extra strobe overflows and is dropped
    do_reset();
    bus.in_ep_grant = 1'b0;
    snap();
    wr_bytes(512, 8'h00);
    @(negedge clk);
    check("t5_ready_full", {31'd0, bus.uart_tx_ready}, 0);
    check("t5_ovf_before", {31'd0, bus.tx_overflow}, 0);
    step();
    bus.uart_tx_data = 8'hEE;
    bus.uart_tx_strobe = 1'b1;
    step();
    bus.uart_tx_strobe = 1'b0;
    @(negedge clk);
    check("t5_ovf_set", {31'd0, bus.tx_overflow}, 1);
    check("t5_ready_still0", {31'd0, bus.uart_tx_ready}, 0);
    step();
    bus.in_ep_grant = 1'b1;
    wait_pkts(16, 1500);
    check("t5_pkts", len_q.size() - base_l, 16);
    check("t5_puts", put_q.size() - base_p, 512);
    errs = 0;
    for (int i = 0; i < 512; i++)
      if (put_q.size() <= base_p + i || put_q[base_p + i] !== 8'(i)) errs++;
    check("t5_byte_errors", errs, 0);
    check("t5_ready_back", {31'd0, bus.uart_tx_ready}, 1);
    check("t5_ovf_sticky", {31'd0, bus.tx_overflow}, 1);
    for (int c = 0; c < F + 40 && zlp_n == base_z; c++) @(negedge clk);
    check("t5_zlp", zlp_n - base_z, 1);

    // 6: reset in the middle of a packet
    do_reset();
    snap();
    wr_bytes(32, 8'h80);
    for (int c = 0; c < 60 && put_q.size() < base_p + 10; c++) @(negedge clk);
    check("t6_reached_10", {31'd0, put_q.size() >= base_p + 10}, 1);
    bus.out_ep_data_avail = 1'b1;
    bus.out_ep_grant = 1'b1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    base_p = put_q.size();
    base_l = len_q.size();
    base_z = zlp_n;
    step();
    bus.out_ep_data_avail = 1'b0;
    bus.out_ep_grant = 1'b0;
    step();
    reset_n = 1'b1;
    early = 1'b0;
    repeat (2 * F + 10) begin
      @(negedge clk);
      if (bus.in_ep_req || bus.in_ep_data_put || bus.in_ep_data_done || bus.uart_rx_valid) early = 1'b1;
    end
    check("t6_quiet_after_reset", {31'd0, early}, 0);
    check("t6_no_done", (len_q.size() - base_l) + (zlp_n - base_z), 0);
    wr_bytes(3, 8'h5A);
    wait_pkts(1, F + 40);
    check("t6_pkts", len_q.size() - base_l, 1);
    if (len_q.size() > base_l) check("t6_len", len_q[base_l], 3);
    for (int i = 0; i < 3; i++)
      if (put_q.size() > base_p + i) check($sformatf("t6_byte%0d", i), {24'd0, put_q[base_p + i]}, 32'h5A + i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
